buffer_arbiter: RTL and testbench
=================================

# buffer_arbiter

Round-robin arbiter and one-entry holding slot that shares a single buffered datapath among several requesters. Each cycle it grants at most one pending requester, latches that requester's data and source index into the slot, and presents the slot to one downstream consumer with a valid/ready handshake. It sits wherever pipeline stages or bus masters contend for a single 1-deep buffer path, for example instruction-fetch versus load/store traffic toward a shared bus port.

## Interface
- DataWidth, 64, width of each requester's data word
- SrcWidth, 2, requester index width; number of requesters NumReq = 1 << SrcWidth
- Clk  input  1  clock; all state updates on rising edge
- Rst  input  1  reset; synchronous, active-high
- ReqValid  input  NumReq  per-requester request; bit i belongs to requester i
- ReqData  input  NumReq*DataWidth  requester i data in bits [i*DataWidth +: DataWidth]
- ReqGrant  output  NumReq  one-hot (or zero) combinational grant; transfer occurs when ReqValid[i] & ReqGrant[i]
- OutValid  output  1  slot holds a word
- OutData  output  DataWidth  slot data
- OutSrc  output  SrcWidth  index of the requester whose word is in the slot
- OutReady  input  1  consumer accepts the slot this cycle
- Busy  output  1  OutValid | (|ReqValid)

## Operation
- Slot state machine with two states, EMPTY (OutValid=0) and FULL (OutValid=1).
- Accept condition Acc: state EMPTY; with FAST_REFILL also state FULL && OutReady.
- Arbitration: a round-robin pointer Ptr (SrcWidth bits) selects the first i with ReqValid[i] set, searching Ptr, Ptr+1, … and wrapping modulo NumReq. ReqGrant[i] = Acc && i is that first index. All other grant bits are 0.
- On a grant edge: OutData <= requester data, OutSrc <= i, OutValid <= 1, Ptr <= (i+1) mod NumReq (natural wrap of SrcWidth bits).
- On a drain edge (OutValid && OutReady) with no grant in the same cycle: OutValid <= 0. OutData and OutSrc keep their last values.
- Ptr changes only on grant edges.
- Requesters hold ReqValid and ReqData stable until granted. A requester that drops ReqValid before grant loses nothing; the arbiter keeps no per-requester state.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NumReq-1,0,… Any valid requester is served within NumReq grants.
- OutReady while EMPTY is ignored. ReqGrant depends only on state, Ptr, ReqValid and OutReady (FAST_REFILL), never on ReqData.

## Timing
- Reset (Rst high at an edge): OutValid=0, OutData=0, OutSrc=0, Ptr=0. ReqGrant is forced to all-zero while Rst is high.
- A reset asserted mid-operation discards any slot content; no grant is taken in a reset cycle.
- Latency: grant in cycle N gives OutValid=1 with the data in cycle N+1.
- Without FAST_REFILL the slot cannot refill in its drain cycle. Peak throughput is one word per 2 cycles. In a drain cycle ReqGrant=0.
- With FAST_REFILL, drain and grant in the same cycle keep OutValid=1 with the new data next cycle, giving one word per cycle.
- Back-pressure: OutReady low keeps the slot FULL, ReqGrant stays 0 and Ptr stays frozen.

## Configuration
- BUFFER_ARBITER_FAST_REFILL_EN defined: Acc also includes FULL && OutReady, giving back-to-back transfers.
- Macro undefined: Acc is EMPTY only. The ReqGrant-to-OutReady combinational path is absent.

## Test plan
- Reset: hold Rst 2 cycles with all ReqValid=1 -> ReqGrant=0 throughout; after release OutValid=0, OutSrc=0, first grant goes to requester 0.
- Single requester: ReqValid=4'b0100, ReqData[2]=64'hA5A5, OutReady=1 -> grant bit 2, next cycle OutValid=1, OutData=64'hA5A5, OutSrc=2, then OutValid=0.
- Rotation: all four valid, OutReady=1, 8 transfers -> OutSrc sequence 0,1,2,3,0,1,2,3. With FAST_REFILL this takes 8 consecutive cycles; without it, every other cycle.
- Back-pressure: slot FULL, OutReady=0 for 5 cycles with ReqValid=4'b1111 -> OutData/OutSrc stable, ReqGrant=0, Ptr unchanged.
- Wrap and skip: Ptr=3 with ReqValid=4'b0010 -> grant 1, next Ptr=2. Then ReqValid=4'b1001 -> grant 3, next Ptr=0.
- Mid-operation reset: slot FULL with OutSrc=3, assert Rst one cycle -> OutValid=0, Ptr=0 next cycle, and no transfer is reported.

Source files
------------

// File: rtl/buffer_arbiter.sv
// ============================================================================
// Module      : buffer_arbiter
// Description : Round-robin arbiter feeding a one-entry holding slot with a
//               valid/ready output. Optional macro BUFFER_ARBITER_FAST_REFILL_EN
//               lets the slot refill in the same cycle it drains.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module buffer_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int SRC_WIDTH  = 2,
  localparam int NUM_REQ   = 1 << SRC_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_grant_o,
  output logic                          out_valid_o,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [SRC_WIDTH-1:0]          out_src_o,
  input  logic                          out_ready_i,
  output logic                          busy_o
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SRC_WIDTH-1:0]  src_q, src_d;
  logic [SRC_WIDTH-1:0]  ptr_q, ptr_d;

  logic                  accept;
  logic                  found;
  logic [SRC_WIDTH-1:0]  win_idx;
  logic [SRC_WIDTH-1:0]  cand;
  logic                  grant_any;

  // First valid requester at or after the pointer, wrapping naturally.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ptr_q + SRC_WIDTH'(k);
      if (!found && req_valid_i[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

`ifdef BUFFER_ARBITER_FAST_REFILL_EN
  assign accept = (state_q == ST_EMPTY) || out_ready_i;
`else
  assign accept = (state_q == ST_EMPTY);
`endif

  // Reset masks the grant so no transfer is reported in a reset cycle.
  assign grant_any   = accept && found && !rst_i;
  assign req_grant_o = grant_any ? (NUM_REQ'(1) << win_idx) : '0;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    src_d   = src_q;
    ptr_d   = ptr_q;
    if (grant_any) begin
      state_d = ST_FULL;
      data_d  = req_data_i[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
      src_d   = win_idx;
      ptr_d   = win_idx + 1'b1;
    end else if ((state_q == ST_FULL) && out_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_valid_o = (state_q == ST_FULL);
  assign out_data_o  = data_q;
  assign out_src_o   = src_q;
  assign busy_o      = out_valid_o || (|req_valid_i);

endmodule

`default_nettype wire

// File: tb/tb_buffer_arbiter.sv
// ============================================================================
// Module      : tb_buffer_arbiter
// Description : Self-checking bench for buffer_arbiter against a slot/pointer
//               reference model. Honours BUFFER_ARBITER_FAST_REFILL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buffer_arbiter;

`ifdef BUFFER_ARBITER_FAST_REFILL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [255:0] req_data = '0;
  logic [3:0]   req_grant;
  logic         out_valid;
  logic [63:0]  out_data;
  logic [1:0]   out_src;
  logic         out_ready = 1'b0;
  logic         busy;

  int tests = 0;
  int fails = 0;

  // reference model: slot contents and round-robin pointer
  bit          m_valid = 1'b0;
  logic [63:0] m_data  = '0;
  int          m_src   = 0;
  int          m_ptr   = 0;
  logic [3:0]  last_g  = '0;

  buffer_arbiter dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_grant_o (req_grant),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_src_o   (out_src),
    .out_ready_i (out_ready),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_grant();
    int i;
    if (rst) return 4'b0000;
    if (m_valid && !(FAST && out_ready)) return 4'b0000;
    for (int k = 0; k < 4; k++) begin
      i = (m_ptr + k) % 4;
      if (req_valid[i]) return 4'(1 << i);
    end
    return 4'b0000;
  endfunction

  task automatic model_clock(input logic [3:0] g);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
    end else if (g != 4'b0000) begin
      for (int i = 0; i < 4; i++) begin
        if (g[i]) begin
          m_data  = req_data[i*64 +: 64];
          m_src   = i;
          m_valid = 1'b1;
          m_ptr   = (i + 1) % 4;
        end
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // advance one clock: outputs settle at posedge+1
  task automatic tick();
    last_g = exp_grant();
    @(posedge clk);
    model_clock(last_g);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic fill_data();
    for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b1; fill_data();
    for (int c = 0; c < 2; c++) begin
      #1;
      tests++;
      if (req_grant !== 4'b0000) begin
        fails++; $display("FAIL reset_grant: got %b want 0000", req_grant);
      end
      tick();
    end
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_src !== 2'd0 || out_data !== 64'd0) begin
      fails++; $display("FAIL reset_state: got v=%b src=%0d data=%h want 0/0/0", out_valid, out_src, out_data);
    end
    #1;
    tests++;
    if (req_grant !== 4'b0001) begin
      fails++; $display("FAIL reset_first_grant: got %b want 0001", req_grant);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 4'b0100; req_data = '0; req_data[2*64 +: 64] = 64'hA5A5; out_ready = 1'b1;
    #1;
    tests++;
    if (req_grant !== 4'b0100) begin
      fails++; $display("FAIL single_grant: got %b want 0100", req_grant);
    end
    tick();
    req_valid = 4'b0000;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 64'hA5A5 || out_src !== 2'd2) begin
      fails++; $display("FAIL single_out: got v=%b data=%h src=%0d want 1/a5a5/2", out_valid, out_data, out_src);
    end
    #1;
    tests++;
    if (req_grant !== 4'b0000) begin
      fails++; $display("FAIL single_no_grant: got %b want 0000", req_grant);
    end
    tick();
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL single_drain: got v=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_rotation();
    int ngr = 0;
    int done_cyc = -1;
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b1; fill_data();
    for (int cyc = 0; cyc < 40 && ngr < 8; cyc++) begin
      #1;
      tests++;
      if (req_grant !== exp_grant()) begin
        fails++; $display("FAIL rot_grant: got %b want %b", req_grant, exp_grant());
      end
      if (req_grant != 4'b0000) begin
        tests++;
        if (req_grant !== 4'(1 << (ngr % 4))) begin
          fails++; $display("FAIL rot_order: got %b want %b", req_grant, 4'(1 << (ngr % 4)));
        end
        ngr++;
        if (ngr == 8) done_cyc = cyc + 1;
      end
      tick();
      tests++;
      if (out_valid !== m_valid || out_data !== m_data || out_src !== 2'(m_src)) begin
        fails++; $display("FAIL rot_out: got v=%b src=%0d data=%h want %b/%0d/%h", out_valid, out_src, out_data, m_valid, m_src, m_data);
      end
    end
    tests++;
    if (done_cyc != (FAST ? 8 : 15)) begin
      fails++; $display("FAIL rot_cycles: got %0d want %0d", done_cyc, FAST ? 8 : 15);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] hold_data;
    logic [1:0]  hold_src;
    bit          seen = 1'b0;
    do_reset();
    req_valid = 4'b1111; out_ready = 1'b0; fill_data();
    #1;
    tests++;
    if (req_grant !== 4'b0001) begin
      fails++; $display("FAIL bp_first: got %b want 0001", req_grant);
    end
    tick();
    hold_data = req_data[63:0];
    hold_src  = 2'd0;
    for (int c = 0; c < 5; c++) begin
      #1;
      tests++;
      if (req_grant !== 4'b0000) begin
        fails++; $display("FAIL bp_grant: got %b want 0000", req_grant);
      end
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== hold_data || out_src !== hold_src) begin
        fails++; $display("FAIL bp_hold: got v=%b src=%0d data=%h want 1/%0d/%h", out_valid, out_src, out_data, hold_src, hold_data);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3 && !seen; c++) begin
      #1;
      if (req_grant != 4'b0000) begin
        seen = 1'b1;
        tests++;
        if (req_grant !== 4'b0010) begin
          fails++; $display("FAIL bp_resume: got %b want 0010", req_grant);
        end
      end
      tick();
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL bp_resume_timeout: got no grant want 0010");
    end
  endtask

  task automatic test_wrap_skip();
    logic [3:0] rv_tab [4] = '{4'b0100, 4'b0010, 4'b1001, 4'b0001};
    logic [3:0] ex_tab [4] = '{4'b0100, 4'b0010, 4'b1000, 4'b0001};
    bit seen;
    do_reset();
    out_ready = 1'b1; fill_data();
    for (int s = 0; s < 4; s++) begin
      req_valid = rv_tab[s];
      seen = 1'b0;
      for (int c = 0; c < 4 && !seen; c++) begin
        #1;
        tests++;
        if (req_grant !== exp_grant()) begin
          fails++; $display("FAIL wrap_model: step %0d got %b want %b", s, req_grant, exp_grant());
        end
        if (req_grant != 4'b0000) begin
          seen = 1'b1;
          tests++;
          if (req_grant !== ex_tab[s]) begin
            fails++; $display("FAIL wrap_grant: step %0d got %b want %b", s, req_grant, ex_tab[s]);
          end
        end
        tick();
      end
      tests++;
      if (!seen) begin
        fails++; $display("FAIL wrap_timeout: step %0d got no grant want %b", s, ex_tab[s]);
      end
      req_valid = req_valid & ~last_g;
    end
  endtask

  task automatic test_midreset();
    do_reset();
    req_valid = 4'b1000; out_ready = 1'b0; fill_data();
    tick();
    req_valid = 4'b0000;
    tests++;
    if (out_valid !== 1'b1 || out_src !== 2'd3) begin
      fails++; $display("FAIL mid_setup: got v=%b src=%0d want 1/3", out_valid, out_src);
    end
    rst = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
    #1;
    tests++;
    if (req_grant !== 4'b0000) begin
      fails++; $display("FAIL mid_grant: got %b want 0000", req_grant);
    end
    tick();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_src !== 2'd0 || out_data !== 64'd0) begin
      fails++; $display("FAIL mid_clear: got v=%b src=%0d data=%h want 0/0/0", out_valid, out_src, out_data);
    end
    #1;
    tests++;
    if (req_grant !== 4'b0001) begin
      fails++; $display("FAIL mid_ptr: got %b want 0001", req_grant);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          req_data[i*64 +: 64] = {$urandom, $urandom};
        end else if (req_valid[i] && ($urandom % 16 == 0)) begin
          req_valid[i] = 1'b0;
        end
      end
      out_ready = ($urandom % 4) != 0;
      rst = ($urandom % 64) == 0;
      #1;
      tests++;
      if (req_grant !== exp_grant()) begin
        fails++; $display("FAIL rand_grant: cyc %0d got %b want %b", c, req_grant, exp_grant());
      end
      tick();
      tests++;
      if (out_valid !== m_valid || out_data !== m_data || out_src !== 2'(m_src) ||
          busy !== (m_valid | (|req_valid))) begin
        fails++; $display("FAIL rand_out: cyc %0d got v=%b src=%0d data=%h busy=%b want %b/%0d/%h/%b",
                          c, out_valid, out_src, out_data, busy, m_valid, m_src, m_data, m_valid | (|req_valid));
      end
      rst = 1'b0;
      req_valid = req_valid & ~last_g;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap_skip();
    test_midreset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
